alu_pipe: RTL and testbench

- Parametrised, handshaked execution unit; next generation of the fixed 3-stage DSP-backed ALU core.
- Behavioural RTL, no primitive instantiation. Configurable data width and pipeline depth.
- Adds valid/ready flow control, flush, a destination tag carried alongside each result, result flags, and an internal multiply-accumulate register.
- Sits between decode/regfile-read and writeback; feeds the forwarding path and the register file.

---
 rtl/alu_pipe_pkg.sv | 17 +
 rtl/alu_pipe_stage.sv | 38 +++
 rtl/alu_pipe.sv | 185 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the alu_pipe execution unit.
// Opcode encodings are also used by the decode stage, so keep them stable.
package alu_pipe_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd5;
  localparam logic [OP_W-1:0] OP_MAC   = 4'd6;
  localparam logic [OP_W-1:0] OP_ACLR  = 4'd7;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd8;

endpackage

// File: rtl/alu_pipe_stage.sv
// One pipeline slot of alu_pipe: a payload register plus its valid bit.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears valid only)
//   flush      clears valid at the next edge
//   adv        whole pipeline advances this cycle; otherwise the slot holds
//   vld_d      incoming valid
//   pay_d      incoming payload (W bits)
//   vld_q      slot valid
//   pay_q      slot payload
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         adv,
  input  logic         vld_d,
  input  logic [W-1:0] pay_d,
  output logic         vld_q,
  output logic [W-1:0] pay_q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  // Payload is qualified by vld_q, so it needs no reset or flush clear.
  always_ff @(posedge clk) begin
    if (adv) begin
      pay_q <= pay_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked, parametrised ALU / multiply-accumulate execution unit.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush_i                    kill all in-flight ops
//   in_valid_i / in_ready_o    input handshake
//   op_i, a_i, b_i, tag_i      operation, operands, destination tag
//   out_valid_o / out_ready_i  output handshake
//   res_o, tag_o               result and its tag
//   carry_o, ovf_o, zero_o, err_o  result flags
// Latency is STAGES cycles from accept to out_valid_o; the whole pipeline
// advances or holds together, driven by the output handshake.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] res_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              carry_o,
  output logic              ovf_o,
  output logic              zero_o,
  output logic              err_o
);

  // Slot 0 holds raw inputs; later slots hold the computed result and flags.
  localparam int PW0 = OP_W + 2 * DATA_W + TAG_W;
  localparam int PW1 = OP_W + DATA_W + 3 + TAG_W;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] r);
    return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] r);
    return ((x < 0) != (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  logic              adv;
  logic [STAGES-1:0] vld_p;
  logic [PW0-1:0]    pay_p0;
  logic [PW1-1:0]    pay_p [1:STAGES-1];
  logic [PW1-1:0]    comp_p0;
  logic [DATA_W-1:0] acc;

  assign in_ready_o = ~(out_valid_o & ~out_ready_i);
  assign adv        = in_ready_o;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    if (k == 0) begin : g_in
      alu_pipe_stage #(.W(PW0)) u_stage (
        .clk(clk), .rst(rst), .flush(flush_i), .adv(adv),
        .vld_d(in_valid_i), .pay_d({op_i, a_i, b_i, tag_i}),
        .vld_q(vld_p[0]), .pay_q(pay_p0)
      );
    end else if (k == 1) begin : g_cmp
      alu_pipe_stage #(.W(PW1)) u_stage (
        .clk(clk), .rst(rst), .flush(flush_i), .adv(adv),
        .vld_d(vld_p[0]), .pay_d(comp_p0),
        .vld_q(vld_p[1]), .pay_q(pay_p[1])
      );
    end else begin : g_dly
      alu_pipe_stage #(.W(PW1)) u_stage (
        .clk(clk), .rst(rst), .flush(flush_i), .adv(adv),
        .vld_d(vld_p[k-1]), .pay_d(pay_p[k-1]),
        .vld_q(vld_p[k]), .pay_q(pay_p[k])
      );
    end
  end

  // ---- slot 0 -> slot 1: main compute ----
  logic [OP_W-1:0]          op_p0;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic [TAG_W-1:0]         tag_p0;
  logic [DATA_W:0]          sum_p0;
  logic [DATA_W:0]          dif_p0;
  logic [2*DATA_W-1:0]      prod_p0;
  logic [DATA_W-1:0]        res_p0;
  logic                     carry_p0;
  logic                     ovf_p0;
  logic                     err_p0;

  assign op_p0   = pay_p0[PW0-1 -: OP_W];
  assign a_p0    = pay_p0[TAG_W + DATA_W +: DATA_W];
  assign b_p0    = pay_p0[TAG_W +: DATA_W];
  assign tag_p0  = pay_p0[TAG_W-1:0];
  assign sum_p0  = {1'b0, a_p0} + {1'b0, b_p0};
  // Top bit of the widened difference is the unsigned borrow (a < b).
  assign dif_p0  = {1'b0, a_p0} - {1'b0, b_p0};
  assign prod_p0 = {{DATA_W{1'b0}}, a_p0} * {{DATA_W{1'b0}}, b_p0};

  always_comb begin
    res_p0   = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    err_p0   = 1'b0;
    case (op_p0)
      OP_ADD: begin
        res_p0   = sum_p0[DATA_W-1:0];
        carry_p0 = sum_p0[DATA_W];
        ovf_p0   = add_ovf(a_p0, b_p0, sum_p0[DATA_W-1:0]);
      end
      OP_SUB: begin
        res_p0   = dif_p0[DATA_W-1:0];
        carry_p0 = dif_p0[DATA_W];
        ovf_p0   = sub_ovf(a_p0, b_p0, dif_p0[DATA_W-1:0]);
      end
      OP_AND:   res_p0 = a_p0 & b_p0;
      OP_OR:    res_p0 = a_p0 | b_p0;
      OP_XOR:   res_p0 = a_p0 ^ b_p0;
      // MAC carries only the product here; the accumulate happens at the
      // output so it always sees the acc left by the preceding MAC.
      OP_MUL, OP_MAC: begin
        res_p0 = prod_p0[DATA_W-1:0];
        ovf_p0 = |prod_p0[2*DATA_W-1:DATA_W];
      end
      OP_ACLR:  res_p0 = '0;
      OP_PASSB: res_p0 = b_p0;
      default:  err_p0 = 1'b1;
    endcase
  end

  assign comp_p0 = {op_p0, res_p0, carry_p0, ovf_p0, err_p0, tag_p0};

  // ---- final slot: accumulate and output drive ----
  logic [PW1-1:0]    pay_f;
  logic [OP_W-1:0]   op_f;
  logic [DATA_W-1:0] res_f;
  logic              carry_f;
  logic              ovf_f;
  logic              err_f;
  logic [TAG_W-1:0]  tag_f;
  logic [DATA_W:0]   mac_sum;
  logic              is_mac;
  logic [DATA_W-1:0] res_sel;

  assign pay_f   = pay_p[STAGES-1];
  assign op_f    = pay_f[PW1-1 -: OP_W];
  assign res_f   = pay_f[TAG_W + 3 +: DATA_W];
  assign carry_f = pay_f[TAG_W + 2];
  assign ovf_f   = pay_f[TAG_W + 1];
  assign err_f   = pay_f[TAG_W];
  assign tag_f   = pay_f[TAG_W-1:0];
  assign is_mac  = (op_f == OP_MAC);
  assign mac_sum = {1'b0, acc} + {1'b0, res_f};
  assign res_sel = is_mac ? mac_sum[DATA_W-1:0] : res_f;

  assign out_valid_o = vld_p[STAGES-1];
  assign res_o       = out_valid_o ? res_sel : '0;
  assign tag_o       = out_valid_o ? tag_f : '0;
  assign carry_o     = out_valid_o & carry_f;
  assign ovf_o       = out_valid_o & (ovf_f | (is_mac & mac_sum[DATA_W]));
  assign err_o       = out_valid_o & err_f;
  assign zero_o      = (res_o == '0);

  // acc commits only when the op actually leaves; flush discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (out_valid_o && out_ready_i && !flush_i) begin
      if (is_mac) begin
        acc <= mac_sum[DATA_W-1:0];
      end else if (op_f == OP_ACLR) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (STAGES = 3, plus 2 and 6 for latency).
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  tag = '0;
  logic        out_ready = 1'b1;

  logic        r3_in_ready, r3_valid, r3_carry, r3_ovf, r3_zero, r3_err;
  logic [31:0] r3_res;
  logic [4:0]  r3_tag;
  logic        r2_in_ready, r2_valid, r2_carry, r2_ovf, r2_zero, r2_err;
  logic [31:0] r2_res;
  logic [4:0]  r2_tag;
  logic        r6_in_ready, r6_valid, r6_carry, r6_ovf, r6_zero, r6_err;
  logic [31:0] r6_res;
  logic [4:0]  r6_tag;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(32), .STAGES(3), .TAG_W(5)) u3 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r3_in_ready),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(r3_valid), .out_ready_i(out_ready),
    .res_o(r3_res), .tag_o(r3_tag), .carry_o(r3_carry), .ovf_o(r3_ovf), .zero_o(r3_zero),
    .err_o(r3_err));

  alu_pipe #(.DATA_W(32), .STAGES(2), .TAG_W(5)) u2 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r2_in_ready),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(r2_valid), .out_ready_i(out_ready),
    .res_o(r2_res), .tag_o(r2_tag), .carry_o(r2_carry), .ovf_o(r2_ovf), .zero_o(r2_zero),
    .err_o(r2_err));

  alu_pipe #(.DATA_W(32), .STAGES(6), .TAG_W(5)) u6 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r6_in_ready),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(r6_valid), .out_ready_i(out_ready),
    .res_o(r6_res), .tag_o(r6_tag), .carry_o(r6_carry), .ovf_o(r6_ovf), .zero_o(r6_zero),
    .err_o(r6_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    tag = t;
  endtask

  // Returns cycles from accept to out_valid on the STAGES=3 unit (0 = timeout).
  task automatic wait_out3(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (r3_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_one(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, output int lat);
    tick();
    drive(o, x, y, t);
    tick();
    in_valid = 1'b0;
    wait_out3(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (r3_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", r3_valid); else n_pass++;
    n_checks++; if (r3_in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", r3_in_ready); else n_pass++;
    n_checks++; if (r3_res !== 32'h0) $display("FAIL reset_res got %h want 0", r3_res); else n_pass++;
    n_checks++; if (r3_tag !== 5'h0) $display("FAIL reset_tag got %h want 0", r3_tag); else n_pass++;
    n_checks++; if ({r3_carry, r3_ovf, r3_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {r3_carry, r3_ovf, r3_err}); else n_pass++;
    n_checks++; if (r3_zero !== 1'b1) $display("FAIL reset_zero got %b want 1", r3_zero); else n_pass++;
  endtask

  task automatic test_add();
    int lat;
    run_one(OP_ADD, 32'd5, 32'd7, 5'd3, lat);
    n_checks++; if (lat !== 3) $display("FAIL add_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (r3_res !== 32'd12) $display("FAIL add_res got %0d want 12", r3_res); else n_pass++;
    n_checks++; if (r3_tag !== 5'd3) $display("FAIL add_tag got %0d want 3", r3_tag); else n_pass++;
    n_checks++; if ({r3_carry, r3_zero, r3_ovf} !== 3'b000) $display("FAIL add_flags got %b want 000", {r3_carry, r3_zero, r3_ovf}); else n_pass++;
  endtask

  task automatic test_sub_ovf();
    int lat;
    run_one(OP_SUB, 32'd0, 32'd1, 5'd1, lat);
    n_checks++; if (r3_res !== 32'hFFFF_FFFF) $display("FAIL sub_res got %h want ffffffff", r3_res); else n_pass++;
    n_checks++; if (r3_carry !== 1'b1) $display("FAIL sub_borrow got %b want 1", r3_carry); else n_pass++;
    n_checks++; if (r3_ovf !== 1'b0) $display("FAIL sub_ovf got %b want 0", r3_ovf); else n_pass++;
    run_one(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd2, lat);
    n_checks++; if (r3_res !== 32'h8000_0000) $display("FAIL addovf_res got %h want 80000000", r3_res); else n_pass++;
    n_checks++; if ({r3_ovf, r3_carry} !== 2'b10) $display("FAIL addovf_flags got %b want 10", {r3_ovf, r3_carry}); else n_pass++;
    run_one(4'd11, 32'd3, 32'd4, 5'd4, lat);
    n_checks++; if ({r3_err, r3_zero} !== 2'b11) $display("FAIL rsvd_flags got %b want 11", {r3_err, r3_zero}); else n_pass++;
    n_checks++; if (r3_res !== 32'h0) $display("FAIL rsvd_res got %h want 0", r3_res); else n_pass++;
    run_one(OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd5, lat);
    n_checks++; if (r3_res !== 32'hFF00_0FF0) $display("FAIL xor_res got %h want ff000ff0", r3_res); else n_pass++;
    run_one(OP_PASSB, 32'd9, 32'h55, 5'd6, lat);
    n_checks++; if ({r3_res, r3_err, r3_carry} !== {32'h55, 2'b00}) $display("FAIL passb got %h/%b want 55/00", r3_res, {r3_err, r3_carry}); else n_pass++;
  endtask

  task automatic test_mac_chain();
    logic [3:0]  tops [4] = '{OP_ACLR, OP_MAC, OP_MAC, OP_MUL};
    logic [31:0] ta   [4] = '{32'd0, 32'd3, 32'd5, 32'h1_0000};
    logic [31:0] tb_  [4] = '{32'd0, 32'd4, 32'd6, 32'h1_0000};
    logic [31:0] exp_res [4] = '{32'd0, 32'd12, 32'd42, 32'd0};
    logic        exp_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] rq [$];
    logic        oq [$];
    int lat;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 4) drive(tops[i], ta[i], tb_[i], 5'(10 + i));
      else in_valid = 1'b0;
      @(negedge clk);
      if (r3_valid) begin
        rq.push_back(r3_res);
        oq.push_back(r3_ovf);
      end
    end
    n_checks++; if (rq.size() !== 4) $display("FAIL mac_count got %0d want 4", rq.size()); else n_pass++;
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      n_checks++;
      if (rq[i] !== exp_res[i] || oq[i] !== exp_ovf[i])
        $display("FAIL mac_chain[%0d] got %0d/%b want %0d/%b", i, rq[i], oq[i], exp_res[i], exp_ovf[i]);
      else n_pass++;
    end
    run_one(OP_MAC, 32'd0, 32'd0, 5'd15, lat);
    n_checks++; if (r3_res !== 32'd42) $display("FAIL acc_after_chain got %0d want 42", r3_res); else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    int sent = 0;
    int stall_left = 0;
    int n_stall = 0;
    bit first_seen = 0;
    bit snap_ok = 0;
    logic [31:0] snap_res = '0;
    logic [4:0]  snap_tag = '0;
    logic [31:0] got_res [$];
    logic [4:0]  got_tag [$];
    for (int it = 0; it < 30; it++) begin
      tick();
      if (r3_valid && !first_seen) begin
        first_seen = 1;
        stall_left = 4;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sent < 6) drive(OP_ADD, 32'(sent + 1), 32'd100, 5'(sent + 1));
      else in_valid = 1'b0;
      @(negedge clk);
      if (r3_valid && !out_ready) begin
        n_stall++;
        n_checks++; if (r3_in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", r3_in_ready); else n_pass++;
        if (!snap_ok) begin
          snap_res = r3_res;
          snap_tag = r3_tag;
          snap_ok  = 1;
        end else begin
          n_checks++;
          if (r3_res !== snap_res || r3_tag !== snap_tag)
            $display("FAIL stall_hold got %0d/%0d want %0d/%0d", r3_res, r3_tag, snap_res, snap_tag);
          else n_pass++;
        end
      end
      if (in_valid && r3_in_ready) sent++;
      if (r3_valid && out_ready) begin
        got_res.push_back(r3_res);
        got_tag.push_back(r3_tag);
      end
    end
    out_ready = 1'b1;
    n_checks++; if (n_stall !== 4) $display("FAIL stall_cycles got %0d want 4", n_stall); else n_pass++;
    n_checks++; if (snap_res !== 32'd101) $display("FAIL stall_first got %0d want 101", snap_res); else n_pass++;
    n_checks++; if (got_res.size() !== 6) $display("FAIL stream_count got %0d want 6", got_res.size()); else n_pass++;
    for (int i = 0; i < 6 && i < got_res.size(); i++) begin
      n_checks++;
      if (got_res[i] !== 32'(101 + i) || got_tag[i] !== 5'(i + 1))
        $display("FAIL stream[%0d] got %0d/%0d want %0d/%0d", i, got_res[i], got_tag[i], 101 + i, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    int lat;
    bit saw = 0;
    tick();
    drive(OP_MAC, 32'd2, 32'd2, 5'd7);
    tick();
    in_valid = 1'b0;
    wait_out3(lat);
    // MAC(2,2) sits in the final slot; flush together with a fresh ADD offer.
    flush = 1'b1;
    drive(OP_ADD, 32'd9, 32'd9, 5'd9);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (r3_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", r3_valid); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (r3_valid) saw = 1;
    end
    n_checks++; if (saw !== 1'b0) $display("FAIL flush_accept got %b want 0", saw); else n_pass++;
    run_one(OP_MAC, 32'd1, 32'd1, 5'd8, lat);
    n_checks++; if (r3_res !== 32'd43) $display("FAIL flush_acc got %0d want 43", r3_res); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int lat;
    tick();
    drive(OP_MAC, 32'd1, 32'd1, 5'd1);
    tick();
    drive(OP_MAC, 32'd1, 32'd1, 5'd2);
    tick();
    drive(OP_MAC, 32'd1, 32'd1, 5'd3);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (r3_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", r3_valid); else n_pass++;
    n_checks++; if (r3_in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", r3_in_ready); else n_pass++;
    run_one(OP_MAC, 32'd0, 32'd0, 5'd4, lat);
    n_checks++; if ({r3_res, r3_zero} !== {32'd0, 1'b1}) $display("FAIL midrst_acc got %0d/%b want 0/1", r3_res, r3_zero); else n_pass++;
  endtask

  task automatic test_latency();
    int lat2 = 0;
    int lat3 = 0;
    int lat6 = 0;
    logic [31:0] res2 = '0;
    logic [31:0] res6 = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(OP_ADD, 32'd5, 32'd7, 5'd3);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (r2_valid && lat2 == 0) begin lat2 = c; res2 = r2_res; end
      if (r3_valid && lat3 == 0) lat3 = c;
      if (r6_valid && lat6 == 0) begin lat6 = c; res6 = r6_res; end
    end
    n_checks++; if (lat2 !== 2) $display("FAIL lat_s2 got %0d want 2", lat2); else n_pass++;
    n_checks++; if (lat3 !== 3) $display("FAIL lat_s3 got %0d want 3", lat3); else n_pass++;
    n_checks++; if (lat6 !== 6) $display("FAIL lat_s6 got %0d want 6", lat6); else n_pass++;
    n_checks++; if (res2 !== 32'd12 || res6 !== 32'd12) $display("FAIL lat_res got %0d/%0d want 12/12", res2, res6); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ovf();
    test_mac_chain();
    test_back_to_back_stall();
    test_flush();
    test_reset_midflight();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
